// File: rtl/hough_pkg.sv
// Shared definitions for the Hough vote engine: FSM states, default widths and
// the constant function that builds the Q1.FRAC_W sin/cos table entries.
package hough_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_X_W      = 10;
  localparam int DEF_Y_W      = 9;
  localparam int DEF_N_ANGLES = 45;
  localparam int DEF_A_W      = 8;
  localparam int DEF_FRAC_W   = 12;
  localparam int DEF_R_W      = 11;
  localparam int DEF_R_BIAS   = 800;

  // Internal fixed-point scale used while evaluating the series expansions.
  localparam int TRIG_SCALE_W = 30;

  // Table entry k of N: round(2^frac_w * cos or sin(k*pi/n)).
  // The angle is folded into [0, pi/2], so a short Taylor series is enough.
  function automatic int trig_q(input int k, input int n, input int frac_w, input logic want_sin);
    longint one_s;
    longint pi_s;
    longint th;
    longint term;
    longint c_acc;
    longint s_acc;
    longint v;
    logic   mirror;
    one_s  = 64'sd1 <<< TRIG_SCALE_W;
    pi_s   = 64'sd3373259426;
    th     = (pi_s * longint'(k)) / longint'(n);
    mirror = ((th * 64'sd2) > pi_s);
    if (mirror) begin
      th = pi_s - th;
    end
    c_acc = 64'sd0;
    term  = one_s;
    for (int i = 1; i <= 9; i++) begin
      c_acc += term;
      term = -((((term * th) / one_s) * th) / one_s) / longint'((2 * i - 1) * (2 * i));
    end
    s_acc = 64'sd0;
    term  = th;
    for (int i = 1; i <= 9; i++) begin
      s_acc += term;
      term = -((((term * th) / one_s) * th) / one_s) / longint'((2 * i) * (2 * i + 1));
    end
    if (mirror) begin
      c_acc = -c_acc;
    end
    v = want_sin ? s_acc : c_acc;
    v = (v + (64'sd1 <<< (TRIG_SCALE_W - 1 - frac_w))) >>> (TRIG_SCALE_W - frac_w);
    return int'(v);
  endfunction

endpackage

// File: rtl/hough_vote_engine_trig_rom.sv
// hough_trig_rom: registered lookup from angle index k to {cos_k, sin_k},
// signed Q1.FRAC_W, with an enable that holds the output while stalled.
import hough_pkg::*;

module hough_trig_rom #(
  parameter int N_ANGLES = DEF_N_ANGLES,
  parameter int A_W      = DEF_A_W,
  parameter int FRAC_W   = DEF_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [A_W-1:0]           k,
  output logic signed [FRAC_W+1:0] cos_q,
  output logic signed [FRAC_W+1:0] sin_q
);

  localparam int T_W   = FRAC_W + 2;
  localparam int DEPTH = 1 << A_W;

  logic signed [T_W-1:0] cos_tab [DEPTH];
  logic signed [T_W-1:0] sin_tab [DEPTH];

  // Indices past N_ANGLES are never issued; they read as zero.
  for (genvar i = 0; i < DEPTH; i++) begin : g_tab
    if (i < N_ANGLES) begin : g_used
      localparam int COS_V = trig_q(i, N_ANGLES, FRAC_W, 1'b0);
      localparam int SIN_V = trig_q(i, N_ANGLES, FRAC_W, 1'b1);
      assign cos_tab[i] = T_W'(COS_V);
      assign sin_tab[i] = T_W'(SIN_V);
    end else begin : g_unused
      assign cos_tab[i] = '0;
      assign sin_tab[i] = '0;
    end
  end

  // Registered table read, frozen while the downstream stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (en) begin
      cos_q <= cos_tab[k];
      sin_q <= sin_tab[k];
    end
  end

endmodule

// File: rtl/hough_vote_engine.sv
// Hough vote generator: one pixel in, N_ANGLES (r, k) votes out.
// Define HOUGH_R_BIAS_EN to emit r + R_BIAS as an unsigned row address.
import hough_pkg::*;

module hough_vote_engine #(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int N_ANGLES = DEF_N_ANGLES,
  parameter int A_W      = DEF_A_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int R_W      = DEF_R_W,
  parameter int R_BIAS   = DEF_R_BIAS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [R_W-1:0] out_r,
  output logic [A_W-1:0] out_angle,
  output logic           out_last,
  output logic           busy
);

  localparam int T_W = FRAC_W + 2;
  localparam int M_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int P_W = M_W + T_W + 2;
  localparam logic [A_W-1:0]        K_LAST   = A_W'(N_ANGLES - 1);
  localparam logic signed [P_W-1:0] RND_HALF = P_W'(2 ** (FRAC_W - 1));

  state_t                state_r;
  state_t                state_s;
  logic [A_W-1:0]        k_r;
  logic [A_W-1:0]        k_s;
  logic                  issue_s;
  logic                  load_s;
  logic                  stall_s;
  logic [X_W-1:0]        x_r;
  logic [Y_W-1:0]        y_r;
  logic                  s1_valid_r;
  logic [A_W-1:0]        s1_k_r;
  logic                  s1_last_r;
  logic signed [T_W-1:0] s1_cos_s;
  logic signed [T_W-1:0] s1_sin_s;
  logic signed [P_W-1:0] x_ext_s;
  logic signed [P_W-1:0] y_ext_s;
  logic signed [P_W-1:0] cos_ext_s;
  logic signed [P_W-1:0] sin_ext_s;
  logic signed [P_W-1:0] p_s;
  logic [R_W-1:0]        r_s;

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r != IDLE);

  // State and angle counter; both freeze on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= '0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
    end
  end

  // Next-state logic: accept in IDLE, issue one angle per free cycle, then drain.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    issue_s = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          load_s  = 1'b1;
          k_s     = '0;
          state_s = SWEEP;
        end else begin
          state_s = IDLE;
        end
      end
      SWEEP: begin
        if (!stall_s) begin
          issue_s = 1'b1;
          if (k_r == K_LAST) begin
            state_s = DRAIN;
          end else begin
            k_s = k_r + A_W'(1);
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Pixel latch; it stays put until the pipeline has fully drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= '0;
      y_r <= '0;
    end else if (load_s) begin
      x_r <= in_x;
      y_r <= in_y;
    end
  end

  hough_trig_rom #(
    .N_ANGLES (N_ANGLES),
    .A_W      (A_W),
    .FRAC_W   (FRAC_W)
  ) u_trig_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall_s),
    .k     (k_r),
    .cos_q (s1_cos_s),
    .sin_q (s1_sin_s)
  );

  // Stage-1 side-band, aligned with the registered table read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_k_r     <= '0;
      s1_last_r  <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= issue_s;
      s1_k_r     <= k_r;
      s1_last_r  <= (k_r == K_LAST);
    end
  end

  // r = round(x*cos + y*sin), half rounded up, then truncated to R_W bits.
  always_comb begin
    x_ext_s   = $signed({{(P_W - X_W){1'b0}}, x_r});
    y_ext_s   = $signed({{(P_W - Y_W){1'b0}}, y_r});
    cos_ext_s = $signed({{(P_W - T_W){s1_cos_s[T_W-1]}}, s1_cos_s});
    sin_ext_s = $signed({{(P_W - T_W){s1_sin_s[T_W-1]}}, s1_sin_s});
    p_s       = (x_ext_s * cos_ext_s) + (y_ext_s * sin_ext_s);
`ifdef HOUGH_R_BIAS_EN
    r_s       = R_W'((p_s + RND_HALF) >>> FRAC_W) + R_W'(R_BIAS);
`else
    r_s       = R_W'((p_s + RND_HALF) >>> FRAC_W);
`endif
  end

  // Output register; held stable while the consumer withholds out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_angle <= '0;
      out_last  <= 1'b0;
    end else if (!stall_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_r     <= r_s;
        out_angle <= s1_k_r;
        out_last  <= s1_last_r;
      end else begin
        out_last  <= 1'b0;
      end
    end
  end

endmodule
